// File: rtl/aes_ctr_sequencer.sv
// AES-CTR counter-block sequencer: key/counter store, job FSM and in-flight limiter.
// Optional build macro AES_CTR_WRAP_HALT_EN: a counter wrap halts issuance until abort or start.
module aes_ctr_sequencer #(
    parameter int WORD_W       = 64,
    parameter int KEY_WORDS    = 4,
    parameter int CTR_W        = 128,
    parameter int INC_W        = 32,
    parameter int LEN_W        = 16,
    parameter int MAX_INFLIGHT = 16,
    localparam int KA_W        = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1,
    localparam int CTR_WORDS   = CTR_W / WORD_W,
    localparam int CA_W        = (CTR_WORDS > 1) ? $clog2(CTR_WORDS) : 1,
    localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [KA_W-1:0]             key_addr,
    input  logic [WORD_W-1:0]           key_wdata,
    input  logic                        key_wen,
    input  logic [CA_W-1:0]             ctr_addr,
    input  logic [WORD_W-1:0]           ctr_wdata,
    input  logic                        ctr_wen,
    input  logic [LEN_W-1:0]            len,
    input  logic                        start,
    input  logic                        abort,
    output logic [KEY_WORDS*WORD_W-1:0] key,
    output logic                        ctr_valid,
    input  logic                        ctr_ready,
    output logic [CTR_W-1:0]            ctr_block,
    input  logic                        blk_done,
    output logic [INF_W-1:0]            inflight,
    output logic                        busy,
    output logic                        done,
    output logic                        wrap_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  key_q [KEY_WORDS];
    logic [WORD_W-1:0]  key_d [KEY_WORDS];
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [LEN_W-1:0]   retired_q, retired_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic               ctr_valid_q, ctr_valid_d;
    logic               done_q, done_d;
    logic               wrap_err_q, wrap_err_d;
    logic               halted_q, halted_d;

    logic               fire;
    logic               retire;
    logic               wrap_fire;

    assign fire      = (state_q == S_RUN) && ctr_valid_q && ctr_ready;
    // Retirements are only meaningful against outstanding blocks of an active job.
    assign retire    = (state_q == S_RUN) && blk_done && (inflight_q != '0);
    assign wrap_fire = fire && (&ctr_q[INC_W-1:0]);

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        retired_d  = retired_q;
        inflight_d = inflight_q;
        wrap_err_d = wrap_err_q;
        halted_d   = halted_q;
        done_d     = (state_q == S_DONE);

        if (fire) begin
            ctr_d[INC_W-1:0] = ctr_q[INC_W-1:0] + INC_W'(1);
            issued_d         = issued_q + LEN_W'(1);
        end
        if (wrap_fire) begin
            wrap_err_d = 1'b1;
`ifdef AES_CTR_WRAP_HALT_EN
            halted_d   = 1'b1;
`endif
        end
        if (retire) begin
            retired_d = retired_q + LEN_W'(1);
        end

        case ({fire, retire})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (key_wen) begin
                    key_d[key_addr] = key_wdata;
                end
                if (ctr_wen) begin
                    ctr_d[int'(ctr_addr)*WORD_W +: WORD_W] = ctr_wdata;
                end
                if (start) begin
                    len_d      = len;
                    issued_d   = '0;
                    retired_d  = '0;
                    inflight_d = '0;
                    wrap_err_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over completion; the counter keeps its next unissued value.
                if (abort) begin
                    state_d    = S_IDLE;
                    inflight_d = '0;
                    halted_d   = 1'b0;
                end else if ((issued_q == len_q) && (retired_q == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ctr_valid_d = (state_d == S_RUN) && (issued_d < len_d) &&
                      (inflight_d < INF_W'(MAX_INFLIGHT)) && !halted_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctr_q       <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            inflight_q  <= '0;
            ctr_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wrap_err_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            inflight_q  <= inflight_d;
            ctr_valid_q <= ctr_valid_d;
            done_q      <= done_d;
            wrap_err_q  <= wrap_err_d;
            halted_q    <= halted_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    key_q[gi] <= '0;
                end else begin
                    key_q[gi] <= key_d[gi];
                end
            end
            assign key[gi*WORD_W +: WORD_W] = key_q[gi];
        end
    endgenerate

    assign ctr_valid = ctr_valid_q;
    assign ctr_block = ctr_q;
    assign inflight  = inflight_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign wrap_err  = wrap_err_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Randomized scoreboard bench for aes_ctr_sequencer against a job-level reference model.
// Honours AES_CTR_WRAP_HALT_EN when the design is built with it.
`timescale 1ns/1ps
module tb_aes_ctr_sequencer;
    localparam int MAXI = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   key_addr = '0;
    logic [63:0]  key_wdata = '0;
    logic         key_wen = 1'b0;
    logic [0:0]   ctr_addr = '0;
    logic [63:0]  ctr_wdata = '0;
    logic         ctr_wen = 1'b0;
    logic [15:0]  len = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [255:0] key;
    logic         ctr_valid;
    logic         ctr_ready = 1'b0;
    logic [127:0] ctr_block;
    logic         blk_done = 1'b0;
    logic [4:0]   inflight;
    logic         busy;
    logic         done;
    logic         wrap_err;

    aes_ctr_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .key_addr(key_addr), .key_wdata(key_wdata), .key_wen(key_wen),
        .ctr_addr(ctr_addr), .ctr_wdata(ctr_wdata), .ctr_wen(ctr_wen),
        .len(len), .start(start), .abort(abort),
        .key(key), .ctr_valid(ctr_valid), .ctr_ready(ctr_ready),
        .ctr_block(ctr_block), .blk_done(blk_done), .inflight(inflight),
        .busy(busy), .done(done), .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, describing the design as seen after the most recent edge.
    bit           m_run = 0, m_dstate = 0, m_done = 0, m_halt = 0, m_wrap = 0;
    int           m_len = 0, m_iss = 0, m_ret = 0, m_inf = 0;
    logic [127:0] m_ctr = '0;
    logic [63:0]  m_key [4] = '{default: '0};
    int           fire_total = 0;
    int           done_total = 0;
    int           due_q[$];
    logic [127:0] exp_q[$];

    bit auto_retire = 0;
    bit force_done = 0;
    int retire_lo = 1, retire_hi = 4;
    logic [63:0] k_words [4] = '{default: '0};

    function automatic logic [127:0] inc_ctr(input logic [127:0] v);
        logic [127:0] mask;
        mask = 128'hFFFF_FFFF;
        return (v & ~mask) | ((v + 128'd1) & mask);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares outputs with the model, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        bit exp_valid, fire_m, ret_m, was_done;
        if (!rst_n) begin
            m_run = 0; m_dstate = 0; m_done = 0; m_halt = 0; m_wrap = 0;
            m_len = 0; m_iss = 0; m_ret = 0; m_inf = 0; m_ctr = '0;
            for (int i = 0; i < 4; i++) m_key[i] = '0;
            due_q.delete();
        end else begin
            exp_valid = m_run && (m_iss < m_len) && (m_inf < MAXI) && !m_halt;
            chk("busy", 256'(busy), 256'(m_run));
            chk("ctr_valid", 256'(ctr_valid), 256'(exp_valid));
            chk("inflight", 256'(inflight), 256'(m_inf));
            chk("wrap_err", 256'(wrap_err), 256'(m_wrap));
            chk("done", 256'(done), 256'(m_done));
            chk("ctr_block", 256'(ctr_block), 256'(m_ctr));
            chk("key", key, {m_key[3], m_key[2], m_key[1], m_key[0]});
            if (done) done_total++;
            if (ctr_valid && ctr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_block: got %0h expected no block", ctr_block);
                end else begin
                    chk("sb_block", 256'(ctr_block), 256'(exp_q.pop_front()));
                end
                $display("fire blk=%h inflight=%0d", ctr_block, inflight);
            end

            fire_m   = exp_valid && ctr_ready;
            was_done = m_dstate;
            m_done   = was_done;
            m_dstate = 0;
            if (fire_m) begin
                fire_total++;
                if (m_ctr[31:0] == 32'hFFFF_FFFF) begin
                    m_wrap = 1;
`ifdef AES_CTR_WRAP_HALT_EN
                    m_halt = 1;
`endif
                end
                m_ctr = inc_ctr(m_ctr);
                if (auto_retire)
                    due_q.push_back(cyc + 1 + int'($urandom_range(retire_lo, retire_hi)));
            end
            if (m_run) begin
                if (abort) begin
                    m_run = 0; m_inf = 0; m_halt = 0;
                end else begin
                    ret_m = blk_done && (m_inf > 0);
                    if (m_iss == m_len && m_ret == m_len) begin
                        m_run = 0;
                        m_dstate = 1;
                    end
                    m_inf = m_inf + (fire_m ? 1 : 0) - (ret_m ? 1 : 0);
                    if (fire_m) m_iss++;
                    if (ret_m) m_ret++;
                end
            end else if (!was_done) begin
                if (key_wen) m_key[key_addr] = key_wdata;
                if (ctr_wen) m_ctr[int'(ctr_addr)*64 +: 64] = ctr_wdata;
                if (start) begin
                    m_len = int'(len); m_iss = 0; m_ret = 0; m_inf = 0;
                    m_wrap = 0; m_halt = 0;
                    if (len == 16'd0) m_dstate = 1;
                    else m_run = 1;
                end
            end
        end
    end

    // AES-core stand-in: retires blocks at their scheduled cycle, or on a forced pulse.
    always @(posedge clk) begin
        #2;
        if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
            blk_done = 1'b1;
            void'(due_q.pop_front());
        end else begin
            blk_done = force_done;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_key(input int a, input logic [63:0] d);
        key_addr = 2'(a); key_wdata = d; key_wen = 1'b1;
        tick();
        key_wen = 1'b0;
        k_words[a] = d;
    endtask

    task automatic load_ctr(input logic [127:0] v);
        for (int w = 0; w < 2; w++) begin
            ctr_addr = 1'(w); ctr_wdata = v[w*64 +: 64]; ctr_wen = 1'b1;
            tick();
        end
        ctr_wen = 1'b0;
    endtask

    task automatic start_job(input int l, input logic [127:0] c0);
        logic [127:0] c;
        c = c0;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(c);
            c = inc_ctr(c);
        end
        $display("job start len=%0d ctr=%h", l, c0);
        len = 16'(l); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rand_ready);
        int d0, n;
        d0 = done_total;
        n = 0;
        while (done_total == d0 && n < budget) begin
            if (rand_ready) ctr_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        tick(3);
        chk({name, "_done_once"}, 256'(done_total - d0), 256'(1));
        chk({name, "_sb_empty"}, 256'(exp_q.size()), 256'(0));
    endtask

    function automatic logic [127:0] rand_ctr();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] c0;
        int f0, d0, l;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_valid", 256'(ctr_valid), 256'(0));
        chk("rst_key", key, 256'(0));
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Randomized complete jobs with random stalls and retirement latency.
        auto_retire = 1; retire_lo = 1; retire_hi = 4;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) write_key(k, {$urandom, $urandom});
            c0 = rand_ctr();
            load_ctr(c0);
            l = int'($urandom_range(1, 24));
            start_job(l, c0);
            wait_done("rand_job", 600, 1);
        end

        // Counter wrap across the low 32 bits.
        ctr_ready = 1'b1; retire_lo = 2; retire_hi = 2;
        c0 = {$urandom, $urandom, $urandom, 32'hFFFF_FFFE};
        load_ctr(c0);
        f0 = fire_total;
        start_job(3, c0);
`ifdef AES_CTR_WRAP_HALT_EN
        tick(20);
        chk("halt_busy", 256'(busy), 256'(1));
        chk("halt_fires", 256'(fire_total - f0), 256'(2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("halt_abort_busy", 256'(busy), 256'(0));
        exp_q.delete();
        tick(4);
`else
        wait_done("wrap_job", 100, 0);
        chk("wrap_fires", 256'(fire_total - f0), 256'(3));
        chk("wrap_err_sticky", 256'(wrap_err), 256'(1));
`endif

        // Backpressure stall; key writes and restarts during RUN must be ignored.
        ctr_ready = 1'b0;
        c0 = rand_ctr();
        load_ctr(c0);
        f0 = fire_total;
        start_job(4, c0);
        key_addr = 2'd1; key_wdata = ~k_words[1]; key_wen = 1'b1;
        len = 16'd1; start = 1'b1;
        tick();
        key_wen = 1'b0; start = 1'b0;
        tick(4);
        chk("stall_blk", 256'(ctr_block), 256'(c0));
        chk("stall_fires", 256'(fire_total - f0), 256'(0));
        chk("stall_valid", 256'(ctr_valid), 256'(1));
        chk("run_key_write", key, {k_words[3], k_words[2], k_words[1], k_words[0]});
        ctr_ready = 1'b1;
        wait_done("stall_job", 100, 0);

        // In-flight limit with no retirements, then forced single and double retirements.
        auto_retire = 0;
        c0 = rand_ctr();
        load_ctr(c0);
        f0 = fire_total;
        start_job(20, c0);
        tick(25);
        chk("limit_fires", 256'(fire_total - f0), 256'(16));
        chk("limit_valid", 256'(ctr_valid), 256'(0));
        chk("limit_inflight", 256'(inflight), 256'(16));
        force_done = 1;
        tick();
        force_done = 0;
        tick(5);
        chk("limit_one_more", 256'(fire_total - f0), 256'(17));
        force_done = 1;
        tick(2);
        force_done = 0;
        tick(5);
        chk("limit_fire_retire", 256'(fire_total - f0), 256'(19));
        chk("limit_inflight2", 256'(inflight), 256'(16));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("limit_abort_inflight", 256'(inflight), 256'(0));
        exp_q.delete();
        tick(2);

        // Zero-length job.
        len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done_early", 256'(done), 256'(0));
        tick();
        chk("zero_done_2cyc", 256'(done), 256'(1));
        tick();
        chk("zero_done_pulse", 256'(done), 256'(0));
        chk("zero_busy", 256'(busy), 256'(0));

        // Abort after two of five fires.
        ctr_ready = 1'b0;
        c0 = rand_ctr();
        load_ctr(c0);
        start_job(5, c0);
        f0 = fire_total;
        d0 = done_total;
        ctr_ready = 1'b1;
        for (int i = 0; i < 20 && (fire_total - f0) < 2; i++) tick();
        ctr_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_fires", 256'(fire_total - f0), 256'(2));
        chk("abort_valid", 256'(ctr_valid), 256'(0));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_inflight", 256'(inflight), 256'(0));
        chk("abort_ctr", 256'(ctr_block), 256'(inc_ctr(inc_ctr(c0))));
        tick(4);
        chk("abort_no_done", 256'(done_total - d0), 256'(0));
        exp_q.delete();

        // Asynchronous reset in the middle of a job.
        auto_retire = 1; ctr_ready = 1'b1;
        c0 = rand_ctr();
        load_ctr(c0);
        start_job(10, c0);
        tick(3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_key", key, 256'(0));
        chk("arst_ctr", 256'(ctr_block), 256'(0));
        chk("arst_valid", 256'(ctr_valid), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_done", 256'(done), 256'(0));
        chk("arst_wrap", 256'(wrap_err), 256'(0));
        chk("arst_inflight", 256'(inflight), 256'(0));
        tick(2);
        rst_n = 1'b1;
        exp_q.delete();
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_ctr_sequencer.md
AES_CTR_SEQUENCER -- requirements
Module: aes_ctr_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter WORD_W, default 64: width of host write words.
REQ-003 Parameter KEY_WORDS, default 4: number of key words; key width = KEY_WORDS*WORD_W.
REQ-004 Parameter CTR_W, default 128: counter block width; an integer multiple of WORD_W.
REQ-005 Parameter INC_W, default 32: number of low counter bits that increment; 1 <= INC_W <= CTR_W.
REQ-006 Parameter LEN_W, default 16: width of the block-count field.
REQ-007 Parameter MAX_INFLIGHT, default 16: maximum number of counter blocks issued but not yet retired.
REQ-008 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- key_addr  in  clog2(KEY_WORDS)  key word index.
- key_wdata  in  WORD_W  key write data.
- key_wen  in  1  key write enable.
- ctr_addr  in  clog2(CTR_W/WORD_W)  counter word index; word 0 = least significant.
- ctr_wdata  in  WORD_W  counter write data.
- ctr_wen  in  1  counter write enable.
- len  in  LEN_W  number of blocks in the job, sampled at start.
- start  in  1  job start pulse.
- abort  in  1  job cancel.
- key  out  KEY_WORDS*WORD_W  stored key.
- ctr_valid  out  1  counter block offered to the AES core.
- ctr_ready  in  1  AES core accepts the block.
- ctr_block  out  CTR_W  counter block.
- blk_done  in  1  pulse: the AES core retired one block.
- inflight  out  clog2(MAX_INFLIGHT+1)  count of outstanding blocks.
- busy  out  1  job active.
- done  out  1  one-cycle job-complete pulse.
- wrap_err  out  1  sticky counter-wrap flag.

Function
REQ-009 The FSM SHALL have three states: IDLE, RUN and DONE; busy SHALL be 1 exactly in RUN.
REQ-010 In IDLE, key_wen/ctr_wen SHALL write the addressed word on the clock edge; in RUN, writes SHALL be ignored.
REQ-011 On start in IDLE, the block SHALL latch len, clear the issued and retired counters, and enter RUN; start outside IDLE SHALL be ignored.
REQ-012 Zero-length job: start with len=0 SHALL go IDLE -> DONE -> IDLE with no issuance, so done asserts 2 cycles after start.
REQ-013 In RUN, ctr_valid SHALL equal (issued < len) AND (inflight < MAX_INFLIGHT) AND NOT halted, and SHALL be registered.
REQ-014 ctr_block SHALL always present the counter register; the value SHALL stay stable while ctr_valid=1 and ctr_ready=0.
REQ-015 On a fire (ctr_valid & ctr_ready), the low INC_W bits SHALL increment modulo 2^INC_W, and the upper CTR_W-INC_W bits SHALL stay unchanged.
REQ-016 A fire SHALL increment both issued and inflight; a blk_done SHALL decrement inflight and increment retired.
REQ-017 A fire and a blk_done in the same cycle SHALL leave inflight unchanged.
REQ-018 blk_done with inflight=0, or while in IDLE, SHALL be ignored: no underflow and no retired increment.
REQ-019 When issued == len and retired == len, RUN SHALL go to DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-020 Abort in RUN SHALL return the FSM to IDLE on the next edge and drop ctr_valid in that cycle, with no done pulse.
REQ-021 After an abort, inflight SHALL be cleared and the counter register SHALL keep the next unissued value.
REQ-022 Abort has priority over start and over the RUN -> DONE transition.
REQ-023 Wrap: a fire whose low INC_W bits are all ones SHALL set wrap_err; wrap_err SHALL be cleared only by reset or by a start.

Reset
REQ-024 While rst_n=0, asynchronously: FSM = IDLE, key = 0, counter register = 0, issued = retired = inflight = 0, ctr_valid = busy = done = wrap_err = 0.

Configuration
REQ-025 With AES_CTR_WRAP_HALT_EN defined, a wrap fire SHALL set an internal halted flag that holds ctr_valid at 0 for the rest of the job.
- The job then completes only via abort; halted is cleared by abort, start or reset.
REQ-026 With AES_CTR_WRAP_HALT_EN undefined, a wrap SHALL only set wrap_err, and issuance SHALL continue with the wrapped counter.

Verification
REQ-027 Load ctr = 0x0..0_FFFFFFFE, len = 3, hold ctr_ready=1 and return blk_done 2 cycles after each fire. Required: blocks ..FFFFFFFE, ..FFFFFFFF, ..00000000 with upper 96 bits unchanged, wrap_err=1 and done once (macro undefined).
- Same stimulus with AES_CTR_WRAP_HALT_EN defined: only 2 blocks issue, busy stays 1, and abort returns the block to IDLE.
REQ-028 Set MAX_INFLIGHT=16, len=20, ctr_ready=1 and no blk_done. Required: exactly 16 fires, then ctr_valid=0 and inflight=16; a single blk_done then allows exactly one more fire.
REQ-029 Hold ctr_ready=0 for 5 cycles with ctr_valid=1. Required: ctr_block is constant and there are no increments; a key_wen during RUN leaves key unchanged.
REQ-030 Start with len=0. Required: done pulses 2 cycles after start and ctr_valid never asserts; a simultaneous fire and blk_done keeps inflight constant.
REQ-031 Abort after 2 of 5 fires. Required: ctr_valid=0 the next cycle, no done, inflight=0, and ctr_block equals the initial counter + 2; assert rst_n low mid-RUN and check every output reaches its reset value without a clock edge.
